// File: rtl/ptw_mem_arbiter.sv
// Round-robin arbiter sharing one page-table memory read port among NREQ page walkers.
// Optional per-requester statistics counters are enabled with `define PTW_ARB_STATS_EN.
module ptw_mem_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*64-1:0] req_addr,
    output logic [NREQ-1:0]    resp_valid,
    output logic               resp_err,
    output logic [63:0]        resp_data,
    output logic               mem_req,
    output logic [63:0]        mem_addr,
    input  logic [63:0]        mem_data,
    input  logic               mem_data_valid
`ifdef PTW_ARB_STATS_EN
    ,
    output logic [NREQ*32-1:0] grant_cnt,
    output logic [31:0]        timeout_cnt
`endif
);

    localparam int GW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TCNT_LAST  = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GRANT_INIT = GW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DRAIN
    } state_t;

    state_t        state;
    logic [GW-1:0] grant;
    logic [GW-1:0] last_grant;
    logic [TW-1:0] tcnt;

    logic [GW-1:0] pick;
    logic [GW-1:0] idx;
    logic          pick_found;
    logic          data_hit;
    logic          err_hit;

    // Round-robin scan starting just after the last requester that got a response.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        pick       = '0;
        idx        = last_grant;
        pick_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = GW'((int'(last_grant) + k) % NREQ);
            if (!pick_found && req_valid[idx]) begin
                pick       = idx;
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        data_hit = (state == BUSY) && mem_data_valid && !flush && req_valid[grant];
        err_hit  = (state == BUSY) && !mem_data_valid && !flush && req_valid[grant]
                   && (tcnt == TCNT_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= GRANT_INIT;
            tcnt       <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            resp_valid <= '0;
            resp_err   <= 1'b0;
            resp_data  <= '0;
        end else begin
            resp_valid <= '0;
            case (state)
                IDLE: begin
                    if (!flush && pick_found) begin
                        grant    <= pick;
                        mem_addr <= req_addr[64*pick +: 64];
                        mem_req  <= 1'b1;
                        tcnt     <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_data_valid) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                        if (data_hit) begin
                            resp_data         <= mem_data;
                            resp_valid[grant] <= 1'b1;
                            resp_err          <= 1'b0;
                            last_grant        <= grant;
                        end
                    end else if (flush || !req_valid[grant]) begin
                        // Read is still in flight at the memory; its data must be swallowed.
                        mem_req <= 1'b0;
                        tcnt    <= '0;
                        state   <= DRAIN;
                    end else if (err_hit) begin
                        resp_valid[grant] <= 1'b1;
                        resp_err          <= 1'b1;
                        resp_data         <= '0;
                        last_grant        <= grant;
                        mem_req           <= 1'b0;
                        tcnt              <= '0;
                        state             <= DRAIN;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                DRAIN: begin
                    if (mem_data_valid || tcnt == TCNT_LAST) begin
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PTW_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_cnt   <= '0;
            timeout_cnt <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (data_hit && grant == GW'(i) && grant_cnt[32*i +: 32] != 32'hFFFF_FFFF) begin
                    grant_cnt[32*i +: 32] <= grant_cnt[32*i +: 32] + 32'd1;
                end
            end
            if (err_hit && timeout_cnt != 32'hFFFF_FFFF) begin
                timeout_cnt <= timeout_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ptw_mem_arbiter.sv
// Directed bench for ptw_mem_arbiter: transaction-level model compared every cycle,
// plus literal expectations for each scenario.
module tb_ptw_mem_arbiter;

    localparam int NREQ    = 2;
    localparam int TIMEOUT = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               flush;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*64-1:0] req_addr;
    logic [NREQ-1:0]    resp_valid;
    logic               resp_err;
    logic [63:0]        resp_data;
    logic               mem_req;
    logic [63:0]        mem_addr;
    logic [63:0]        mem_data;
    logic               mem_data_valid;
`ifdef PTW_ARB_STATS_EN
    logic [NREQ*32-1:0] grant_cnt;
    logic [31:0]        timeout_cnt;
`endif

    ptw_mem_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .resp_valid     (resp_valid),
        .resp_err       (resp_err),
        .resp_data      (resp_data),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mem_data_valid (mem_data_valid)
`ifdef PTW_ARB_STATS_EN
        ,
        .grant_cnt      (grant_cnt),
        .timeout_cnt    (timeout_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a walk is either open, being drained, or absent.
    bit              walk_open    = 1'b0;
    bit              late_pending = 1'b0;
    int              owner        = 0;
    int              age          = 0;
    int              last_g       = NREQ - 1;
    logic            e_mem_req    = 1'b0;
    logic [63:0]     e_mem_addr   = '0;
    logic [NREQ-1:0] e_resp_valid = '0;
    logic            e_resp_err   = 1'b0;
    logic [63:0]     e_resp_data  = '0;

    task automatic model_reset();
        walk_open    = 1'b0;
        late_pending = 1'b0;
        owner        = 0;
        age          = 0;
        last_g       = NREQ - 1;
        e_mem_req    = 1'b0;
        e_mem_addr   = '0;
        e_resp_valid = '0;
        e_resp_err   = 1'b0;
        e_resp_data  = '0;
    endtask

    task automatic respond(input bit err, input logic [63:0] d);
        e_resp_valid        = '0;
        e_resp_valid[owner] = 1'b1;
        e_resp_err          = err;
        e_resp_data         = d;
        last_g              = owner;
    endtask

    task automatic model_step();
        e_resp_valid = '0;
        if (walk_open) begin
            if (mem_data_valid) begin
                walk_open = 1'b0;
                e_mem_req = 1'b0;
                if (!flush && req_valid[owner]) respond(1'b0, mem_data);
            end else if (flush || !req_valid[owner]) begin
                walk_open    = 1'b0;
                late_pending = 1'b1;
                age          = 0;
                e_mem_req    = 1'b0;
            end else if (age == TIMEOUT - 1) begin
                respond(1'b1, 64'd0);
                walk_open    = 1'b0;
                late_pending = 1'b1;
                age          = 0;
                e_mem_req    = 1'b0;
            end else begin
                age++;
            end
        end else if (late_pending) begin
            if (mem_data_valid || age == TIMEOUT - 1) late_pending = 1'b0;
            else age++;
        end else if (!flush && req_valid != '0) begin
            for (int k = 1; k <= NREQ; k++) begin
                int c;
                c = (last_g + k) % NREQ;
                if (!walk_open && req_valid[c]) begin
                    owner     = c;
                    walk_open = 1'b1;
                end
            end
            age        = 0;
            e_mem_req  = 1'b1;
            e_mem_addr = req_addr[owner*64 +: 64];
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("mdl_mem_req", mem_req, e_mem_req);
            if (e_mem_req) check("mdl_mem_addr", mem_addr, e_mem_addr);
            check("mdl_resp_valid", resp_valid, e_resp_valid);
            if (e_resp_valid != '0) begin
                check("mdl_resp_err", resp_err, e_resp_err);
                check("mdl_resp_data", resp_data, e_resp_data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic give_data(input logic [63:0] d);
        mem_data       = d;
        mem_data_valid = 1'b1;
        tick();
        mem_data_valid = 1'b0;
    endtask

    task automatic wait_mem_req(input string name);
        int n;
        n = 0;
        while (!mem_req && n < 40) begin
            tick();
            n++;
        end
        check(name, mem_req, 1);
    endtask

    localparam logic [63:0] ADDR0 = 64'h8000_1000;
    localparam logic [63:0] ADDR1 = 64'h8000_2000;

    initial begin
        int n;
        int exp_g;
        logic [NREQ-1:0] exp_rv;

        reset          = 1'b0;
        flush          = 1'b0;
        req_valid      = '0;
        req_addr       = '0;
        mem_data       = '0;
        mem_data_valid = 1'b0;
        repeat (3) tick();
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_resp_data", resp_data, 0);
        reset = 1'b1;

        // Stray data while idle must be ignored.
        give_data(64'hDEAD_BEEF);
        tick();
        check("idle_stray_resp", resp_valid, 0);
        check("idle_stray_req", mem_req, 0);

        // Single walk, data three cycles after the request.
        req_addr[63:0]   = ADDR0;
        req_addr[127:64] = ADDR1;
        req_valid        = 2'b01;
        tick();
        check("t1_mem_req", mem_req, 1);
        check("t1_mem_addr", mem_addr, ADDR0);
        tick();
        tick();
        give_data(64'h2000_0C01);
        check("t1_resp_valid", resp_valid, 2'b01);
        check("t1_resp_data", resp_data, 64'h2000_0C01);
        check("t1_resp_err", resp_err, 0);
        req_valid = 2'b00;

        // Both requesters held: grants alternate, starting after requester 0.
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp_g  = (k + 1) % 2;
            exp_rv = (exp_g == 1) ? 2'b10 : 2'b01;
            wait_mem_req("t2_mem_req");
            check("t2_mem_addr", mem_addr, (exp_g == 1) ? ADDR1 : ADDR0);
            tick();
            give_data(64'h1000 + 64'(k));
            check("t2_resp_valid", resp_valid, exp_rv);
            check("t2_resp_data", resp_data, 64'h1000 + 64'(k));
        end
        req_valid = 2'b00;

        // Flush two cycles into the walk; late data drained before regrant.
        req_valid = 2'b10;
        wait_mem_req("t3_mem_req");
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t3_req_fall", mem_req, 0);
        tick();
        tick();
        give_data(64'hBAD0);
        check("t3_late_drop", resp_valid, 0);
        check("t3_wait_drain", mem_req, 0);
        tick();
        check("t3_regrant", mem_req, 1);
        check("t3_regrant_addr", mem_addr, ADDR1);
        tick();
        give_data(64'h3333);
        check("t3_resp_valid", resp_valid, 2'b10);
        req_valid = 2'b00;

        // Flush coinciding with data: read is complete, no drain needed.
        req_valid = 2'b01;
        wait_mem_req("t3b_mem_req");
        flush = 1'b1;
        give_data(64'h4444);
        flush = 1'b0;
        check("t3b_no_resp", resp_valid, 0);
        check("t3b_req_fall", mem_req, 0);
        tick();
        check("t3b_no_drain", mem_req, 1);
        tick();
        give_data(64'h5555);
        check("t3b_resp_valid", resp_valid, 2'b01);
        req_valid = 2'b00;

        // Silent memory: error response 8 cycles after mem_req rose, then 8-cycle drain.
        req_valid = 2'b10;
        wait_mem_req("t4_mem_req");
        n = 0;
        while (resp_valid == '0 && n < 20) begin
            tick();
            n++;
        end
        check("t4_err_latency", 64'(n), 8);
        check("t4_resp_valid", resp_valid, 2'b10);
        check("t4_resp_err", resp_err, 1);
        check("t4_resp_data", resp_data, 0);
        req_valid = 2'b01;
        n = 0;
        while (!mem_req && n < 30) begin
            tick();
            n++;
        end
        check("t4_drain_len", 64'(n), 9);
        check("t4_next_addr", mem_addr, ADDR0);
        tick();
        give_data(64'h6666);
        check("t4_resp_valid2", resp_valid, 2'b01);
        req_valid = 2'b00;

        // Requester 1 abandons mid-walk while requester 0 waits.
        req_valid = 2'b11;
        wait_mem_req("t5_mem_req");
        check("t5_mem_addr", mem_addr, ADDR1);
        tick();
        req_valid = 2'b01;
        tick();
        check("t5_abandon", mem_req, 0);
        tick();
        give_data(64'h7777);
        check("t5_no_resp", resp_valid, 0);
        tick();
        check("t5_regrant", mem_req, 1);
        check("t5_regrant_addr", mem_addr, ADDR0);
        tick();
        give_data(64'h8888);
        check("t5_resp_valid", resp_valid, 2'b01);
        check("t5_resp_data", resp_data, 64'h8888);
        req_valid = 2'b00;

        // Asynchronous reset mid-walk.
        req_valid = 2'b01;
        wait_mem_req("t6_mem_req");
        tick();
        #2 reset = 1'b0;
        #1;
        check("t6_async_mem_req", mem_req, 0);
        check("t6_async_resp", resp_valid, 0);
`ifdef PTW_ARB_STATS_EN
        check("t6_grant_cnt", grant_cnt, 0);
        check("t6_timeout_cnt", timeout_cnt, 0);
`endif
        req_valid = 2'b00;
        tick();
        tick();
        reset     = 1'b1;
        req_valid = 2'b11;
        wait_mem_req("t6_post_req");
        check("t6_first_prio", mem_addr, ADDR0);
        tick();
        give_data(64'h9999);
        check("t6_resp_valid", resp_valid, 2'b01);
        req_valid = 2'b00;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
